// File: rtl/subscript_gen.sv
// Two-level loop-nest subscript generator: emits (i0*stride0, i1*stride1)
// per accepted beat using incremental stride accumulation.
module subscript_gen #(
    parameter int NBIT_FLAT_ADDR = 16,
    parameter int NBIT_BOUND     = 8,
    parameter int N_SUBSCRIPTS   = 2
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         start_i,
    input  logic                                         flush_i,
    input  logic [NBIT_BOUND-1:0]                        bound0_i,
    input  logic [NBIT_BOUND-1:0]                        bound1_i,
    input  logic [NBIT_FLAT_ADDR-1:0]                    stride0_i,
    input  logic [NBIT_FLAT_ADDR-1:0]                    stride1_i,
    output logic [N_SUBSCRIPTS-1:0][NBIT_FLAT_ADDR-1:0]  subscripts_o,
    output logic                                         valid_o,
    input  logic                                         ready_i,
    output logic                                         last_o,
    output logic                                         busy_o,
    output logic                                         done_o
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [NBIT_BOUND-1:0]     B_ONE = NBIT_BOUND'(1);
    localparam logic [NBIT_BOUND-1:0]     B_ZERO = '0;
    localparam logic [NBIT_FLAT_ADDR-1:0] A_ZERO = '0;

    state_t                    r_state;
    logic [NBIT_BOUND-1:0]     r_b0;
    logic [NBIT_BOUND-1:0]     r_b1;
    logic [NBIT_FLAT_ADDR-1:0] r_st0;
    logic [NBIT_FLAT_ADDR-1:0] r_st1;
    logic [NBIT_BOUND-1:0]     r_i0;
    logic [NBIT_BOUND-1:0]     r_i1;
    logic [NBIT_FLAT_ADDR-1:0] r_sub0;
    logic [NBIT_FLAT_ADDR-1:0] r_sub1;
    logic                      r_done;

    logic w_run;
    logic w_end0;
    logic w_end1;
    logic w_last;

    assign w_run  = (r_state == RUN);
    assign w_end0 = (r_i0 == r_b0 - B_ONE);
    assign w_end1 = (r_i1 == r_b1 - B_ONE);
    assign w_last = w_run & w_end0 & w_end1;

    // All outputs decode flops only; ready_i never reaches an output.
    assign subscripts_o[0] = r_sub0;
    assign subscripts_o[1] = r_sub1;
    assign valid_o         = w_run;
    assign busy_o          = w_run;
    assign last_o          = w_last;
    assign done_o          = r_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_b0    <= B_ZERO;
            r_b1    <= B_ZERO;
            r_st0   <= A_ZERO;
            r_st1   <= A_ZERO;
            r_i0    <= B_ZERO;
            r_i1    <= B_ZERO;
            r_sub0  <= A_ZERO;
            r_sub1  <= A_ZERO;
            r_done  <= 1'b0;
        end else if (flush_i) begin
            r_state <= IDLE;
            r_i0    <= B_ZERO;
            r_i1    <= B_ZERO;
            r_sub0  <= A_ZERO;
            r_sub1  <= A_ZERO;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_b0   <= bound0_i;
                        r_b1   <= bound1_i;
                        r_st0  <= stride0_i;
                        r_st1  <= stride1_i;
                        r_i0   <= B_ZERO;
                        r_i1   <= B_ZERO;
                        r_sub0 <= A_ZERO;
                        r_sub1 <= A_ZERO;
                        // An empty iteration space completes without beats.
                        if (bound0_i != B_ZERO && bound1_i != B_ZERO)
                            r_state <= RUN;
                        else
                            r_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (ready_i) begin
                        if (w_last) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                            r_i0    <= B_ZERO;
                            r_i1    <= B_ZERO;
                            r_sub0  <= A_ZERO;
                            r_sub1  <= A_ZERO;
                        end else if (!w_end0) begin
                            r_i0   <= r_i0 + B_ONE;
                            r_sub0 <= r_sub0 + r_st0;
                        end else begin
                            r_i0   <= B_ZERO;
                            r_sub0 <= A_ZERO;
                            r_i1   <= r_i1 + B_ONE;
                            r_sub1 <= r_sub1 + r_st1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subscript_gen.sv
// Directed bench for subscript_gen: sequences, stalls, empty runs,
// wrap, flush, async reset, start-ignore and back-to-back runs.
module tb_subscript_gen;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              flush;
    logic [7:0]        bound0;
    logic [7:0]        bound1;
    logic [15:0]       stride0;
    logic [15:0]       stride1;
    logic [1:0][15:0]  subs;
    logic              valid;
    logic              ready;
    logic              last;
    logic              busy;
    logic              done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    subscript_gen dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .flush_i      (flush),
        .bound0_i     (bound0),
        .bound1_i     (bound1),
        .stride0_i    (stride0),
        .stride1_i    (stride1),
        .subscripts_o (subs),
        .valid_o      (valid),
        .ready_i      (ready),
        .last_o       (last),
        .busy_o       (busy),
        .done_o       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_last"},  32'(last),  32'd0);
        chk({tag, "_done"},  32'(done),  32'(exp_done));
    endtask

    // Starts a run and walks it to the done cycle; returns in that cycle.
    task automatic run_seq(input string tag, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [15:0] s0,
                           input logic [15:0] s1, input bit stall,
                           input bit noise);
        logic [15:0] e0;
        logic [15:0] e1;
        logic        el;
        bound0 = b0; bound1 = b1; stride0 = s0; stride1 = s1;
        start = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        if (noise) begin
            start = 1'b1;
            bound0 = b0 + 8'd3; bound1 = b1 + 8'd1;
            stride0 = s0 + 16'd5; stride1 = s1 + 16'd7;
        end
        if (b0 == 8'd0 || b1 == 8'd0) begin
            chk_idle({tag, "_empty"}, 1'b1);
            start = 1'b0;
            return;
        end
        for (int j = 0; j < int'(b1); j++) begin
            for (int i = 0; i < int'(b0); i++) begin
                e0 = 16'(i * int'(s0));
                e1 = 16'(j * int'(s1));
                el = (i == int'(b0) - 1) && (j == int'(b1) - 1);
                if (stall) begin
                    ready = 1'b0;
                    for (int k = 0; k < 2; k++) begin
                        chk({tag, "_hold_valid"}, 32'(valid), 32'd1);
                        chk({tag, "_hold_s0"}, 32'(subs[0]), 32'(e0));
                        chk({tag, "_hold_s1"}, 32'(subs[1]), 32'(e1));
                        chk({tag, "_hold_last"}, 32'(last), 32'(el));
                        tick();
                    end
                end
                chk({tag, "_valid"}, 32'(valid), 32'd1);
                chk({tag, "_busy"},  32'(busy),  32'd1);
                chk({tag, "_done"},  32'(done),  32'd0);
                chk({tag, "_s0"},    32'(subs[0]), 32'(e0));
                chk({tag, "_s1"},    32'(subs[1]), 32'(e1));
                chk({tag, "_last"},  32'(last),  32'(el));
                ready = 1'b1;
                tick();
            end
        end
        start = 1'b0;
        chk_idle({tag, "_end"}, 1'b1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; ready = 1'b0;
        bound0 = '0; bound1 = '0; stride0 = '0; stride1 = '0;
        tick();
        chk_idle("reset", 1'b0);
        chk("reset_s0", 32'(subs[0]), 32'd0);
        chk("reset_s1", 32'(subs[1]), 32'd0);
        rst = 1'b0;
        tick();

        run_seq("basic", 8'd3, 8'd2, 16'd1, 16'd4, 1'b0, 1'b0);
        tick();
        chk_idle("basic_post", 1'b0);

        run_seq("stall", 8'd3, 8'd2, 16'd1, 16'd4, 1'b1, 1'b0);
        tick();
        chk_idle("stall_post", 1'b0);

        run_seq("zb0", 8'd0, 8'd5, 16'd1, 16'd1, 1'b0, 1'b0);
        tick();
        chk_idle("zb0_post", 1'b0);
        run_seq("zb1", 8'd4, 8'd0, 16'd1, 16'd1, 1'b0, 1'b0);
        tick();
        chk_idle("zb1_post", 1'b0);

        run_seq("wrap", 8'd3, 8'd1, 16'h8000, 16'd9, 1'b0, 1'b0);
        tick();
        chk_idle("wrap_post", 1'b0);

        // Flush on the third beat, with a competing start that must drop.
        bound0 = 8'd3; bound1 = 8'd2; stride0 = 16'd1; stride1 = 16'd4;
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("fl_s0_beat3", 32'(subs[0]), 32'd2);
        chk("fl_valid_beat3", 32'(valid), 32'd1);
        flush = 1'b1; start = 1'b1;
        tick();
        flush = 1'b0; start = 1'b0;
        chk_idle("flush", 1'b0);
        chk("flush_s0", 32'(subs[0]), 32'd0);
        tick();
        chk_idle("flush_post", 1'b0);
        run_seq("restart", 8'd3, 8'd2, 16'd1, 16'd4, 1'b0, 1'b0);
        tick();

        // Asynchronous reset in the middle of a run.
        bound0 = 8'd3; bound1 = 8'd2; stride0 = 16'd2; stride1 = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rst_pre_s0", 32'(subs[0]), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk_idle("rst_async", 1'b0);
        chk("rst_async_s0", 32'(subs[0]), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk_idle("rst_post", 1'b0);

        // Start during RUN is ignored; start in the done cycle chains.
        run_seq("noise", 8'd2, 8'd2, 16'd1, 16'd10, 1'b0, 1'b1);
        run_seq("b2b", 8'd2, 8'd1, 16'd3, 16'd0, 1'b0, 1'b0);
        tick();
        chk_idle("final", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
